note_stabilizer: RTL and testbench

Per-frame note debouncer between the harmonic-product-spectrum pitch detector and the note bus that drives the GPO pins and the synthesizer. It receives one note vector and one spectral power value per completed FFT frame. It only publishes a note after it has been seen on several consecutive qualifying frames, and only drops it after several non-qualifying frames. Power thresholds with hysteresis suppress flicker from noise and from octave jumps between frames.

---
 rtl/note_stabilizer.sv | 137 +++++++++++++
 tb/tb_note_stabilizer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/note_stabilizer.sv
// Debounces per-frame pitch-detector notes: publish after ON_FRAMES qualifying frames, drop after OFF_FRAMES misses.
// Outputs registered, 1 cycle after a strobe; strobes may arrive back-to-back and none are lost.
module note_stabilizer #(
    parameter int                NOTE_W     = 25,
    parameter int                POW_W      = 32,
    parameter int                ON_FRAMES  = 3,
    parameter int                OFF_FRAMES = 4,
    parameter logic [POW_W-1:0]  POW_ON     = 4096,
    parameter logic [POW_W-1:0]  POW_OFF    = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_valid,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [POW_W-1:0]  i_power,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_change,
    output logic              o_active
);

    if (ON_FRAMES < 2 || ON_FRAMES > 15) begin : g_bad_on_frames
        $error("note_stabilizer: ON_FRAMES must be 2..15");
    end
    if (OFF_FRAMES < 1 || OFF_FRAMES > 15) begin : g_bad_off_frames
        $error("note_stabilizer: OFF_FRAMES must be 1..15");
    end
    if (POW_OFF > POW_ON) begin : g_bad_pow
        $error("note_stabilizer: POW_OFF must not exceed POW_ON");
    end

    localparam logic [3:0] ON_CNT  = 4'(ON_FRAMES);
    localparam logic [3:0] OFF_CNT = 4'(OFF_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_HOLD, S_RELEASE} state_t;

    state_t              state_q, state_d;
    logic [NOTE_W-1:0]   cand_q, cand_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                change_q, change_d;
    logic                is_onehot, qual, sustain, drop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cand_q   <= '0;
            note_q   <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            note_q   <= note_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        is_onehot = (i_note != '0) && ((i_note & (i_note - NOTE_W'(1))) == '0);
        qual      = is_onehot && (i_power >= POW_ON);
        sustain   = (i_note == note_q) && (i_power >= POW_OFF);
        state_d   = state_q;
        cand_d    = cand_q;
        note_d    = note_q;
        cnt_d     = cnt_q;
        drop      = 1'b0;
        if (i_frame_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (qual) begin
                        cand_d  = i_note;
                        cnt_d   = 4'd1;
                        state_d = S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (qual && i_note == cand_q) begin
                        if (cnt_q + 4'd1 == ON_CNT) begin
                            note_d  = cand_q;
                            cnt_d   = 4'd0;
                            state_d = S_HOLD;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (qual) begin
                        cand_d = i_note;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (sustain) begin
                        cnt_d = 4'd0;
                    end else if (OFF_CNT == 4'd1) begin
                        drop = 1'b1;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = S_RELEASE;
                    end
                end
                default: begin
                    if (sustain) begin
                        cnt_d   = 4'd0;
                        state_d = S_HOLD;
                    end else if (cnt_q + 4'd1 == OFF_CNT) begin
                        drop = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            endcase
            // A dropping frame is re-evaluated as if it had arrived in IDLE.
            if (drop) begin
                note_d = '0;
                if (qual) begin
                    cand_d  = i_note;
                    cnt_d   = 4'd1;
                    state_d = S_ATTACK;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
        end
        change_d = (note_d != note_q);
    end

    always_comb begin
        o_note   = note_q;
        o_change = change_q;
        o_active = (state_q == S_HOLD) || (state_q == S_RELEASE);
    end

endmodule

// File: tb/tb_note_stabilizer.sv
// Scoreboard bench for note_stabilizer: a frame-level reference model pushes expected outputs per cycle.
module tb_note_stabilizer;

    localparam int ON  = 3;
    localparam int OFF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fv = 1'b0;
    logic [24:0] nt = '0;
    logic [31:0] pw = '0;
    logic [24:0] o_note;
    logic        o_change, o_active;

    typedef struct {
        logic [24:0] note;
        logic        chg;
        logic        act;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;

    logic [24:0] m_held = '0;
    logic [24:0] m_cand = '0;
    int          m_run = 0;
    int          m_miss = 0;

    note_stabilizer #(
        .NOTE_W(25), .POW_W(32), .ON_FRAMES(ON), .OFF_FRAMES(OFF),
        .POW_ON(32'd4096), .POW_OFF(32'd1024)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_valid(fv), .i_note(nt), .i_power(pw),
        .o_note(o_note), .o_change(o_change), .o_active(o_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model(input logic r, input logic v, input logic [24:0] n, input logic [31:0] p);
        exp_t        e;
        logic [24:0] prev;
        logic        q;
        prev = m_held;
        if (r) begin
            m_held = '0; m_cand = '0; m_run = 0; m_miss = 0;
        end else if (v) begin
            q = ($countones(n) == 1) && (p >= 32'd4096);
            if (m_held != '0) begin
                if (n == m_held && p >= 32'd1024) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == OFF) begin
                        m_held = '0; m_miss = 0; m_run = 0;
                    end
                end
            end
            if (m_held == '0) begin
                if (q) begin
                    if (m_run > 0 && n == m_cand) m_run++;
                    else begin m_cand = n; m_run = 1; end
                    if (m_run == ON) begin m_held = m_cand; m_run = 0; end
                end else m_run = 0;
            end
        end
        e.note = m_held;
        e.chg  = !r && (m_held != prev);
        e.act  = (m_held != '0);
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic [24:0] n, input logic [31:0] p);
        exp_t e;
        rst = r; fv = v; nt = n; pw = p;
        model(r, v, n, p);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_note", 32'(o_note), 32'(e.note));
        check("sb_change", 32'(o_change), 32'(e.chg));
        check("sb_active", 32'(o_active), 32'(e.act));
        rst = 1'b0; fv = 1'b0;
    endtask

    task automatic strobes(input logic [24:0] n, input logic [31:0] p, input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b1, n, p);
    endtask

    initial begin
        logic [24:0] pick [4];
        logic [31:0] pows [3];
        pick[0] = 25'h0; pick[1] = 25'h8; pick[2] = 25'h200; pick[3] = 25'h30;
        pows[0] = 32'd500; pows[1] = 32'd2000; pows[2] = 32'd5000;

        #2;
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 25'h20, 32'd5000);
        check("rst_note", 32'(o_note), 32'h0);
        check("rst_active", 32'(o_active), 32'h0);

        // basic publish
        strobes(25'h20, 32'd5000, 2);
        check("pre_pub_note", 32'(o_note), 32'h0);
        strobes(25'h20, 32'd5000, 1);
        check("pub_note", 32'(o_note), 32'h20);
        check("pub_change", 32'(o_change), 32'h1);
        check("pub_active", 32'(o_active), 32'h1);
        step(1'b0, 1'b0, '0, '0);
        check("pub_change_end", 32'(o_change), 32'h0);

        // sustain / release / recover, then drop
        strobes(25'h20, 32'd2000, 2);
        strobes(25'h0, 32'd0, 3);
        strobes(25'h20, 32'd2000, 1);
        check("recover_note", 32'(o_note), 32'h20);
        strobes(25'h0, 32'd0, 3);
        check("pre_drop_note", 32'(o_note), 32'h20);
        strobes(25'h0, 32'd0, 1);
        check("drop_note", 32'(o_note), 32'h0);
        check("drop_change", 32'(o_change), 32'h1);
        check("drop_active", 32'(o_active), 32'h0);

        // candidate switch restarts the count
        strobes(25'h20, 32'd5000, 2);
        strobes(25'h80, 32'd5000, 2);
        check("switch_hold_zero", 32'(o_note), 32'h0);
        strobes(25'h80, 32'd5000, 1);
        check("switch_pub", 32'(o_note), 32'h80);
        strobes(25'h0, 32'd0, 4);

        // multi-bit and under-power frames never qualify
        strobes(25'h30, 32'd9000, 3);
        check("multibit_note", 32'(o_note), 32'h0);
        strobes(25'h4, 32'd4095, 3);
        check("lowpow_note", 32'(o_note), 32'h0);

        // inputs ignored without strobe
        strobes(25'h20, 32'd5000, 2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 25'($urandom), $urandom);
        check("frozen_note", 32'(o_note), 32'h0);
        strobes(25'h20, 32'd5000, 1);
        check("frozen_pub", 32'(o_note), 32'h20);

        // reset beats a strobe while holding
        step(1'b1, 1'b1, 25'h20, 32'd5000);
        check("hold_rst_note", 32'(o_note), 32'h0);
        check("hold_rst_change", 32'(o_change), 32'h0);
        check("hold_rst_active", 32'(o_active), 32'h0);
        strobes(25'h20, 32'd5000, 3);
        check("post_rst_pub", 32'(o_note), 32'h20);

        // random back-to-back traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                 pick[$urandom_range(0, 3)], pows[$urandom_range(0, 2)]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
